// File: rtl/fb_mem_initiator_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fb_mem_initiator_if                                       |
// | Purpose  : Pixel stream and frame-buffer memory command signals of   |
// |            the frame-buffer memory initiator, bundled as one         |
// |            interface.                                                |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface fb_mem_initiator_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 29
);
    // Pixel write stream
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_pixel;
    logic                  wr_ready;

    // Pixel read requests and returned data
    logic                  rd_req;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_pixel;

    // End-of-frame markers
    logic                  wr_frame_done;
    logic                  rd_frame_done;

    // Memory command port (enables are active-low)
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    // View of the initiator itself
    modport master (
        input  wr_valid, wr_pixel, rd_req, mem_rd_data,
        output wr_ready, rd_ready, rd_valid, rd_pixel,
               wr_frame_done, rd_frame_done,
               mem_wr_addr, mem_rd_addr, mem_wr_data, mem_wr_en, mem_rd_en
    );

    // View of the surrounding pipelines and memory
    modport slave (
        output wr_valid, wr_pixel, rd_req, mem_rd_data,
        input  wr_ready, rd_ready, rd_valid, rd_pixel,
               wr_frame_done, rd_frame_done,
               mem_wr_addr, mem_rd_addr, mem_wr_data, mem_wr_en, mem_rd_en
    );
endinterface
`default_nettype wire

// File: rtl/fb_mem_initiator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fb_mem_initiator                                          |
// | Purpose  : Converts a pixel write stream and pixel read requests     |
// |            into held, active-low memory commands with wrapping       |
// |            frame pointers and alternating write/read arbitration.    |
// |            BASE_ADDR must be nonzero, FRAME_SIZE >= 2,               |
// |            CMD_CYCLES >= 3.                                          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fb_mem_initiator #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 29,
    parameter int unsigned BASE_ADDR  = 1,
    parameter int unsigned FRAME_SIZE = 307200,
    parameter int          CMD_CYCLES = 3
) (
    input  wire logic          clk,
    input  wire logic          reset,
    fb_mem_initiator_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_CMD = 3'd1,
        S_RD_CMD = 3'd2,
        S_RD_CAP = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    localparam logic c_grant_write = 1'b0;
    localparam logic c_grant_read  = 1'b1;

    localparam int                    c_cnt_w    = $clog2(CMD_CYCLES) + 1;
    localparam logic [c_cnt_w-1:0]    c_cnt_last = c_cnt_w'(CMD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0]    c_cnt_one  = c_cnt_w'(1);
    localparam logic [ADDR_WIDTH-1:0] c_base     = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] c_last     = ADDR_WIDTH'(BASE_ADDR + FRAME_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_addr_one = ADDR_WIDTH'(1);

    state_t                r_state;
    logic                  r_last_grant;
    logic [c_cnt_w-1:0]    r_cmd_cnt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH-1:0] r_mem_wr_addr;
    logic [ADDR_WIDTH-1:0] r_mem_rd_addr;
    logic [DATA_WIDTH-1:0] r_mem_wr_data;
    logic                  r_mem_wr_en;
    logic                  r_mem_rd_en;
    logic [DATA_WIDTH-1:0] r_rd_pixel;
    logic                  r_rd_valid;
    logic                  r_wr_frame_done;
    logic                  r_rd_frame_done;

    logic w_idle;
    logic w_wr_ready;
    logic w_rd_ready;
    logic w_wr_accept;
    logic w_rd_accept;

    // Alternating grant: a contended request goes to whichever side did not win last.
    // When both requests are present exactly one ready is high, so the accepts are exclusive.
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_wr_ready  = w_idle && (!bus.rd_req   || (r_last_grant == c_grant_read));
        w_rd_ready  = w_idle && (!bus.wr_valid || (r_last_grant == c_grant_write));
        w_wr_accept = bus.wr_valid && w_wr_ready;
        w_rd_accept = bus.rd_req   && w_rd_ready;
    end

    // Command sequencer: issues one held command at a time and advances the frame pointers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_last_grant    <= c_grant_read;
            r_cmd_cnt       <= '0;
            r_wr_ptr        <= c_base;
            r_rd_ptr        <= c_base;
            r_mem_wr_addr   <= c_base;
            r_mem_rd_addr   <= c_base;
            r_mem_wr_data   <= '0;
            r_mem_wr_en     <= 1'b1;
            r_mem_rd_en     <= 1'b1;
            r_rd_pixel      <= '0;
            r_rd_valid      <= 1'b0;
            r_wr_frame_done <= 1'b0;
            r_rd_frame_done <= 1'b0;
        end else begin
            // Pulses last a single cycle unless re-armed below.
            r_rd_valid      <= 1'b0;
            r_wr_frame_done <= 1'b0;
            r_rd_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_wr_accept) begin
                        r_mem_wr_data <= bus.wr_pixel;
                        r_mem_wr_addr <= r_wr_ptr;
                        r_mem_wr_en   <= 1'b0;
                        r_cmd_cnt     <= '0;
                        r_last_grant  <= c_grant_write;
                        r_state       <= S_WR_CMD;
                    end else if (w_rd_accept) begin
                        r_mem_rd_addr <= r_rd_ptr;
                        r_mem_rd_en   <= 1'b0;
                        r_cmd_cnt     <= '0;
                        r_last_grant  <= c_grant_read;
                        r_state       <= S_RD_CMD;
                    end
                end

                // Enable stays low for CMD_CYCLES cycles after the accepting edge.
                S_WR_CMD: begin
                    if (r_cmd_cnt == c_cnt_last) begin
                        r_mem_wr_en <= 1'b1;
                        r_state     <= S_GAP;
                        if (r_wr_ptr == c_last) begin
                            r_wr_ptr        <= c_base;
                            r_wr_frame_done <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_addr_one;
                        end
                    end else begin
                        r_cmd_cnt <= r_cmd_cnt + c_cnt_one;
                    end
                end

                // The read data is sampled on the last held edge, while the memory is
                // still driving it, so rd_pixel is valid in the same cycle as rd_valid.
                S_RD_CMD: begin
                    if (r_cmd_cnt == c_cnt_last) begin
                        r_mem_rd_en <= 1'b1;
                        r_rd_pixel  <= bus.mem_rd_data;
                        r_rd_valid  <= 1'b1;
                        r_state     <= S_RD_CAP;
                    end else begin
                        r_cmd_cnt <= r_cmd_cnt + c_cnt_one;
                    end
                end

                // Both enables are already high here, so this cycle doubles as the
                // memory's return-to-idle cycle and keeps the read turnaround at
                // CMD_CYCLES + 2.
                S_RD_CAP: begin
                    r_state <= S_IDLE;
                    if (r_rd_ptr == c_last) begin
                        r_rd_ptr        <= c_base;
                        r_rd_frame_done <= 1'b1;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + c_addr_one;
                    end
                end

                S_GAP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_mem_wr_en <= 1'b1;
                    r_mem_rd_en <= 1'b1;
                end
            endcase
        end
    end

    assign bus.wr_ready      = w_wr_ready;
    assign bus.rd_ready      = w_rd_ready;
    assign bus.rd_valid      = r_rd_valid;
    assign bus.rd_pixel      = r_rd_pixel;
    assign bus.wr_frame_done = r_wr_frame_done;
    assign bus.rd_frame_done = r_rd_frame_done;
    assign bus.mem_wr_addr   = r_mem_wr_addr;
    assign bus.mem_rd_addr   = r_mem_rd_addr;
    assign bus.mem_wr_data   = r_mem_wr_data;
    assign bus.mem_wr_en     = r_mem_wr_en;
    assign bus.mem_rd_en     = r_mem_rd_en;

endmodule
`default_nettype wire
